multdiv_unit: RTL

Parametrised iterative signed multiply/divide unit for the pipelined processor's execute stage, used for the R-type mul/div ALU ops.
- Operands are captured on a one-cycle start pulse.
- The unit iterates one bit per cycle and pulses a result-ready strobe.
- The processor stalls the pipeline while busy is high.
- Successor to the single-cycle ALU path: adds width parametrisation, multicycle sequencing, abort/restart, and exception reporting.

---
 rtl/multdiv_unit.sv | 133 +++++++++++++
 1 files changed

// File: rtl/multdiv_unit.sv
// Iterative signed multiply/divide, one bit per cycle: strobe in the cycle after start edge + WIDTH+1.
// A start during any state restarts the op. MULTDIV_EARLY_OUT_EN finishes trivial operands after one edge.
module multdiv_unit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             ctrl_MULT,
   input  logic             ctrl_DIV,
   input  logic [WIDTH-1:0] data_operandA,
   input  logic [WIDTH-1:0] data_operandB,
   output logic [WIDTH-1:0] data_result,
   output logic             data_exception,
   output logic             data_resultRDY,
   output logic             busy
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t r_state, w_nxt;

   logic               r_op_mul, r_sa, r_sb;
   logic [WIDTH-1:0]   r_ma, r_mb, r_quot;
   logic [2*WIDTH-1:0] r_prod;
   logic [WIDTH:0]     r_rem;
   logic [CNT_W-1:0]   r_cnt;

   logic               w_start, w_last, w_early, w_finish, w_neg, w_ge, w_mul_exc, w_exc;
   logic [WIDTH-1:0]   w_mag_a, w_mag_b, w_quot_s, w_res;
   logic [WIDTH:0]     w_sum, w_shift;
   logic [2*WIDTH-1:0] w_prod_s;

   assign w_start = ctrl_MULT | ctrl_DIV;
   assign w_mag_a = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
   assign w_mag_b = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
   assign w_last  = (r_cnt == CNT_W'(WIDTH));

`ifdef MULTDIV_EARLY_OUT_EN
   assign w_early = (r_mb == '0) || (r_op_mul && (r_ma == '0));
`else
   assign w_early = 1'b0;
`endif

   assign w_finish = (r_state == RUN) && !w_start && (w_last || w_early);

   // Shift-add step: the upper half plus carry is re-aligned on every right shift.
   assign w_sum   = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + (r_prod[0] ? {1'b0, r_ma} : '0);
   // Restoring-division step: bring the next dividend bit into the remainder.
   assign w_shift = {r_rem[WIDTH-1:0], r_quot[WIDTH-1]};
   assign w_ge    = (w_shift >= {1'b0, r_mb});

   assign w_neg     = r_sa ^ r_sb;
   assign w_prod_s  = w_neg ? -r_prod : r_prod;
   assign w_quot_s  = w_neg ? -r_quot : r_quot;
   assign w_mul_exc = !((&w_prod_s[2*WIDTH-1:WIDTH-1]) || !(|w_prod_s[2*WIDTH-1:WIDTH-1]));

   always_comb begin
      w_res = w_prod_s[WIDTH-1:0];
      w_exc = w_mul_exc;
      if (!r_op_mul) begin
         if (r_mb == '0) begin
            w_res = '0;
            w_exc = 1'b1;
         end else begin
            // Only MIN_INT / -1 yields a positive quotient with the top bit set.
            w_res = w_quot_s;
            w_exc = !w_neg && r_quot[WIDTH-1];
         end
      end
      if (w_early) begin
         w_res = '0;
         w_exc = !r_op_mul;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) r_state <= IDLE;
      else        r_state <= w_nxt;
   end

   always_comb begin
      w_nxt = r_state;
      case (r_state)
         IDLE:    if (w_start) w_nxt = RUN;
         RUN:     if (w_start) w_nxt = RUN;
                  else if (w_last || w_early) w_nxt = DONE;
         DONE:    w_nxt = w_start ? RUN : IDLE;
         default: w_nxt = IDLE;
      endcase
   end

   assign busy           = (r_state == RUN);
   assign data_resultRDY = (r_state == DONE);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_op_mul       <= 1'b0;
         r_sa           <= 1'b0;
         r_sb           <= 1'b0;
         r_ma           <= '0;
         r_mb           <= '0;
         r_quot         <= '0;
         r_prod         <= '0;
         r_rem          <= '0;
         r_cnt          <= '0;
         data_result    <= '0;
         data_exception <= 1'b0;
      end else if (w_start) begin
         r_op_mul <= ctrl_MULT;
         r_sa     <= data_operandA[WIDTH-1];
         r_sb     <= data_operandB[WIDTH-1];
         r_ma     <= w_mag_a;
         r_mb     <= w_mag_b;
         r_prod   <= {{WIDTH{1'b0}}, w_mag_b};
         r_quot   <= w_mag_a;
         r_rem    <= '0;
         r_cnt    <= '0;
      end else if (w_finish) begin
         data_result    <= w_res;
         data_exception <= w_exc;
      end else if (r_state == RUN) begin
         r_cnt <= r_cnt + CNT_W'(1);
         if (r_op_mul) begin
            r_prod <= {w_sum, r_prod[WIDTH-1:1]};
         end else begin
            r_rem  <= w_ge ? (w_shift - {1'b0, r_mb}) : w_shift;
            r_quot <= {r_quot[WIDTH-2:0], w_ge};
         end
      end
   end

endmodule
